clock_rate_scheduler: RTL and testbench

Programmable clock-rate controller that generates the divided square-wave `clock_out` from `clock_in` and schedules every change to it. It owns the run/stop sequencing and a request/acknowledge port through which other logic (mode select, speed-up switch) requests a new divisor. Each change is applied only at a period boundary, so `clock_out` never produces a truncated high or low phase. It sits between the FPGA input clock and all logic that runs off the slow or sped-up clock.

---
 rtl/clock_rate_scheduler.sv | 135 +++++++++++++
 tb/tb_clock_rate_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clock_rate_scheduler.sv
`default_nettype none
// ============================================================================
//  clock_rate_scheduler : divided clock generator with run/stop sequencing
//  and period-boundary divisor updates.               Revision 1.0
// ============================================================================
module clock_rate_scheduler #(
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 25000000,
    parameter int unsigned MIN_DIV     = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             active,
    output logic             tick,
    output logic             clock_out
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             busy_q,    busy_d;
    logic             clk_out_q, clk_out_d;
    logic             ack_q,     ack_d;
    logic             err_q,     err_d;

    logic [WIDTH-1:0] w_half;
    logic             w_boundary;

    assign w_half     = cur_div_q >> 1;
    assign w_boundary = (cnt_q == (cur_div_q - C_ONE));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STOPPED;
            cnt_q      <= '0;
            cur_div_q  <= C_DEFAULT_DIV;
            pend_div_q <= '0;
            busy_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            busy_q     <= busy_d;
            clk_out_q  <= clk_out_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        busy_d     = busy_q;
        clk_out_d  = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        // Requests arriving while one is pending are dropped silently.
        if (div_req && !busy_q) begin
            if (div_value < C_MIN_DIV) begin
                err_d = 1'b1;
            end else begin
                pend_div_d = div_value;
                busy_d     = 1'b1;
            end
        end

        case (state_q)
            STOPPED: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (busy_q) begin
                    cur_div_d = pend_div_q;
                    busy_d    = 1'b0;
                    ack_d     = 1'b1;
                end
                if (run) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                clk_out_d = (cnt_q < w_half);
                if (w_boundary) begin
                    // Divisor and run/stop changes only take effect between periods.
                    cnt_d = '0;
                    if (busy_q) begin
                        cur_div_d = pend_div_q;
                        busy_d    = 1'b0;
                        ack_d     = 1'b1;
                    end
                    if (!run) begin
                        state_d = STOPPED;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: begin
                state_d = STOPPED;
                cnt_d   = '0;
            end
        endcase
    end

    assign div_ack   = ack_q;
    assign div_err   = err_q;
    assign busy      = busy_q;
    assign active    = (state_q == RUNNING);
    assign tick      = (state_q == RUNNING) && (cnt_q == '0);
    assign clock_out = clk_out_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_rate_scheduler.sv
`default_nettype none
// Directed-vector bench for clock_rate_scheduler with DEFAULT_DIV=10.
module tb_clock_rate_scheduler;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        run      = 1'b0;
    logic        div_req  = 1'b0;
    logic [27:0] div_value = '0;
    logic        div_ack, div_err, busy, active, tick, clock_out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        run;
        logic        req;
        logic [27:0] val;
        logic        tick;
        logic        co;
        logic        act;
        logic        busy;
        logic        ack;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    clock_rate_scheduler #(
        .WIDTH(28),
        .DEFAULT_DIV(10),
        .MIN_DIV(2)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .run      (run),
        .div_req  (div_req),
        .div_value(div_value),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .busy     (busy),
        .active   (active),
        .tick     (tick),
        .clock_out(clock_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic q, input int v,
                       input logic t, input logic c, input logic a,
                       input logic b, input logic k, input logic e);
        vec_t x;
        x.run = r; x.req = q; x.val = 28'(v);
        x.tick = t; x.co = c; x.act = a; x.busy = b; x.ack = k; x.err = e;
        tbl.push_back(x);
    endtask

    // Inputs are driven at a falling edge and outputs checked at the next one.
    task automatic step(input vec_t v, input string tag);
        run       = v.run;
        div_req   = v.req;
        div_value = v.val;
        @(posedge clock_in);
        @(negedge clock_in);
        chk({tag, " tick"},      tick,      v.tick);
        chk({tag, " clock_out"}, clock_out, v.co);
        chk({tag, " active"},    active,    v.act);
        chk({tag, " busy"},      busy,      v.busy);
        chk({tag, " div_ack"},   div_ack,   v.ack);
        chk({tag, " div_err"},   div_err,   v.err);
    endtask

    initial begin
        vec_t v;
        // run req val | tick co act busy ack err
        // start with default divisor 10: 5 high / 5 low
        add(1,0,0, 1,0,1,0,0,0);
        for (int i = 0; i < 5; i++) add(1,0,0, 0,1,1,0,0,0);
        for (int i = 0; i < 4; i++) add(1,0,0, 0,0,1,0,0,0);
        add(1,0,0, 1,0,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        // request 4 during cnt=2, adopted at the wrap
        add(1,1,4, 0,1,1,1,0,0);
        add(1,0,0, 0,1,1,1,0,0);
        add(1,0,0, 0,1,1,1,0,0);
        for (int i = 0; i < 4; i++) add(1,0,0, 0,0,1,1,0,0);
        add(1,0,0, 1,0,1,0,1,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,0,1,0,0,0);
        add(1,0,0, 1,0,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        // reject 1, accept 3, ignore 6 while busy
        add(1,1,1, 0,1,1,0,0,1);
        add(1,1,3, 0,0,1,1,0,0);
        add(1,1,6, 1,0,1,0,1,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,0,1,0,0,0);
        add(1,0,0, 1,0,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,0,1,0,0,0);
        // request in boundary cycle waits a full period
        add(1,1,10, 1,0,1,1,0,0);
        add(1,0,0, 0,1,1,1,0,0);
        add(1,0,0, 0,0,1,1,0,0);
        add(1,0,0, 1,0,1,0,1,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);
        // drop run at cnt=3: finish the period, full low phase
        add(0,0,0, 0,1,1,0,0,0);
        add(0,0,0, 0,1,1,0,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0, 0,0,1,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        // stopped request of 7, then 3 high / 4 low
        add(0,1,7, 0,0,0,1,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(1,0,0, 1,0,1,0,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0, 0,1,1,0,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0, 0,0,1,0,0,0);
        add(1,0,0, 1,0,1,0,0,0);
        add(1,0,0, 0,1,1,0,0,0);

        repeat (3) @(negedge clock_in);
        chk("reset tick",      tick,      1'b0);
        chk("reset clock_out", clock_out, 1'b0);
        chk("reset active",    active,    1'b0);
        chk("reset busy",      busy,      1'b0);
        chk("reset div_ack",   div_ack,   1'b0);
        chk("reset div_err",   div_err,   1'b0);
        reset_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("step%0d", i));

        // Request pending in a high phase (div 7, cnt=1), then async reset.
        v = '{run:1'b1, req:1'b1, val:28'd5, tick:1'b0, co:1'b1,
              act:1'b1, busy:1'b1, ack:1'b0, err:1'b0};
        step(v, "pre_reset");
        div_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async clock_out", clock_out, 1'b0);
        chk("async busy",      busy,      1'b0);
        chk("async active",    active,    1'b0);
        chk("async tick",      tick,      1'b0);
        chk("async div_ack",   div_ack,   1'b0);
        run = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_in);
            chk($sformatf("post_reset%0d div_ack", i), div_ack, 1'b0);
            chk($sformatf("post_reset%0d busy", i),    busy,    1'b0);
        end

        // Divisor back to default 10 after reset.
        for (int i = 0; i <= 10; i++) begin
            v = '{run:1'b1, req:1'b0, val:28'd0,
                  tick:(i == 0 || i == 10), co:(i >= 1 && i <= 5),
                  act:1'b1, busy:1'b0, ack:1'b0, err:1'b0};
            step(v, $sformatf("default%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
